// File: rtl/cordic_rr_scheduler.sv
// Round-robin front end for one shared fixed-latency cosine CORDIC core.
// A tag pipe follows each operand through the core so that its result goes back to the requester that issued it.
module cordic_rr_scheduler #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned LATENCY = 14,
   parameter int unsigned DATA_W  = 32
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]     req_data,
   output logic [NUM_REQ-1:0]            rsp_valid,
   input  logic [NUM_REQ-1:0]            rsp_ready,
   output logic [DATA_W-1:0]             rsp_data,
   output logic                          cordic_aclr,
   output logic                          cordic_clk_en,
   output logic [DATA_W-1:0]             cordic_dataa,
   input  logic [DATA_W-1:0]             cordic_result,
   output logic [$clog2(LATENCY+2)-1:0]  in_flight
);

   localparam int unsigned TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned DEPTH = LATENCY + 1;
   localparam int unsigned IF_W  = $clog2(LATENCY + 2);

   logic [TAG_W-1:0] ptr;
   logic [DEPTH-1:0] pipe_v;
   logic [TAG_W-1:0] pipe_tag [DEPTH];
   logic             out_valid;
   logic [TAG_W-1:0] out_tag;
   logic             stall;
   logic             deliver;
   logic             accept;
   logic             any_grant;
   logic [TAG_W-1:0] grant;
   int unsigned      idx;

   assign out_valid     = pipe_v[DEPTH-1];
   assign out_tag       = pipe_tag[DEPTH-1];
   assign stall         = out_valid & ~rsp_ready[out_tag];
   assign deliver       = out_valid & rsp_ready[out_tag];
   assign accept        = any_grant & ~stall & ~reset;
   assign cordic_aclr   = reset;
   assign cordic_clk_en = ~stall;
   assign rsp_data      = cordic_result;

   // Search starts one past the last granted requester
   always_comb begin
      any_grant = 1'b0;
      grant     = '0;
      idx       = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(ptr) + k) % NUM_REQ;
         if (!any_grant && req_valid[TAG_W'(idx)]) begin
            any_grant = 1'b1;
            grant     = TAG_W'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant] = 1'b1;
   end

   always_comb begin
      rsp_valid          = '0;
      rsp_valid[out_tag] = out_valid;
   end

   // Tag pipe, operand register and pointer all freeze together with the core
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr          <= '0;
         pipe_v       <= '0;
         cordic_dataa <= '0;
         in_flight    <= '0;
         for (int unsigned k = 0; k < DEPTH; k++) pipe_tag[k] <= '0;
      end else begin
         if (!stall) begin
            pipe_v      <= {pipe_v[DEPTH-2:0], accept};
            pipe_tag[0] <= accept ? grant : '0;
            for (int unsigned k = 1; k < DEPTH; k++) pipe_tag[k] <= pipe_tag[k-1];
            if (accept) begin
               ptr          <= grant;
               cordic_dataa <= req_data[32'(grant)*DATA_W +: DATA_W];
            end
         end
         in_flight <= in_flight + IF_W'(accept) - IF_W'(deliver);
      end
   end

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Randomised and directed bench for cordic_rr_scheduler against a queue-based transaction model.
// A stand-in core with the same latency and clock-enable/aclr behaviour replaces the real CORDIC.
module tb_cordic_rr_scheduler;

   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned LATENCY = 14;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned IF_W    = $clog2(LATENCY + 2);
   localparam int unsigned TW      = 1;

   logic                      clock;
   logic                      reset;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [NUM_REQ-1:0]        rsp_ready;
   logic [DATA_W-1:0]         rsp_data;
   logic                      cordic_aclr;
   logic                      cordic_clk_en;
   logic [DATA_W-1:0]         cordic_dataa;
   logic [DATA_W-1:0]         cordic_result;
   logic [IF_W-1:0]           in_flight;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   cordic_rr_scheduler #(.NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .DATA_W(DATA_W)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .cordic_aclr(cordic_aclr), .cordic_clk_en(cordic_clk_en),
      .cordic_dataa(cordic_dataa), .cordic_result(cordic_result),
      .in_flight(in_flight)
   );

   // Stand-in core: known cosine pair plus an arbitrary scrambler for everything else
   function automatic logic [DATA_W-1:0] core_fn(input logic [DATA_W-1:0] x);
      if (x == 32'h3F06_6B2D) return 32'h6EC1_BCCD;
      return (x * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   logic [DATA_W-1:0] core_pipe [LATENCY];
   always @(posedge clock) begin
      if (cordic_aclr) begin
         for (int i = 0; i < int'(LATENCY); i++) core_pipe[i] <= '0;
      end else if (cordic_clk_en) begin
         core_pipe[0] <= core_fn(cordic_dataa);
         for (int i = 1; i < int'(LATENCY); i++) core_pipe[i] <= core_pipe[i-1];
      end
   end
   assign cordic_result = core_pipe[LATENCY-1];

   typedef struct {
      int unsigned       tag;
      logic [DATA_W-1:0] res;
      int unsigned       age;
   } op_t;

   op_t               q[$];
   int unsigned       ptr_m;
   logic [DATA_W-1:0] last_dataa;
   bit                acc_m, dlv_m, stall_m;
   int unsigned       g_m;
   int                n_chk, n_pass;

   logic [NUM_REQ-1:0] s_req_ready, s_rsp_valid;
   logic [IF_W-1:0]    s_in_flight;
   logic [DATA_W-1:0]  s_rsp_data;
   logic               s_clk_en;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic rand_data();
      for (int i = 0; i < int'(NUM_REQ); i++) req_data[i*DATA_W +: DATA_W] = $urandom();
   endtask

   // One clock: compare at negedge against the model, then advance the model at the edge
   task automatic step();
      bit                 ov, found;
      int unsigned        idx;
      logic [NUM_REQ-1:0] exp_rdy, exp_rv;
      @(negedge clock);
      ov      = (q.size() > 0) && (q[0].age == LATENCY);
      stall_m = 1'b0;
      if (ov) stall_m = !rsp_ready[TW'(q[0].tag)];
      dlv_m = ov && !stall_m;
      found = 1'b0;
      g_m   = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (ptr_m + k) % NUM_REQ;
         if (!found && req_valid[TW'(idx)]) begin
            found = 1'b1;
            g_m   = idx;
         end
      end
      acc_m   = found && !stall_m && !reset;
      exp_rdy = '0;
      if (acc_m) exp_rdy[TW'(g_m)] = 1'b1;
      exp_rv = '0;
      if (ov) exp_rv[TW'(q[0].tag)] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (ov) chk("rsp_data", 64'(rsp_data), 64'(q[0].res));
      chk("clk_en", 64'(cordic_clk_en), 64'(!stall_m));
      chk("aclr", 64'(cordic_aclr), 64'(reset));
      chk("in_flight", 64'(in_flight), 64'(q.size()));
      chk("dataa", 64'(cordic_dataa), 64'(last_dataa));
      s_req_ready = req_ready;
      s_rsp_valid = rsp_valid;
      s_in_flight = in_flight;
      s_rsp_data  = rsp_data;
      s_clk_en    = cordic_clk_en;
      @(posedge clock);
      if (reset) begin
         q.delete();
         ptr_m      = 0;
         last_dataa = '0;
      end else begin
         if (dlv_m) void'(q.pop_front());
         if (!stall_m) foreach (q[i]) q[i].age++;
         if (acc_m) begin
            last_dataa = req_data[g_m*DATA_W +: DATA_W];
            q.push_back('{tag: g_m, res: core_fn(last_dataa), age: 0});
            ptr_m = g_m;
         end
      end
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, sent0, sent1, ng, nacc, peak, nrsp, first, last, nbad;
      logic [NUM_REQ-1:0] gseq [4];
      logic [DATA_W-1:0]  held;
      n_chk = 0; n_pass = 0;
      reset = 1'b1; req_valid = '0; rsp_ready = '1; req_data = '0;
      ptr_m = 0; last_dataa = '0;
      @(posedge clock); #1;
      step(); step();
      reset = 1'b0;

      // Idle after reset
      nbad = 0;
      repeat (20) begin
         step();
         if (s_rsp_valid != 0 || s_in_flight != 0 || !s_clk_en) nbad++;
      end
      chk("t6_idle", 64'(nbad), 64'(0));

      // Single op, known operand
      rand_data();
      req_valid = 2'b01; req_data[DATA_W-1:0] = 32'h3F06_6B2D; rsp_ready = 2'b11;
      step();
      chk("t1_accept", 64'(s_req_ready), 64'(2'b01));
      req_valid = '0;
      lat = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         step();
         if (s_rsp_valid[0]) begin
            lat = k;
            chk("t1_data", 64'(s_rsp_data), 64'(32'h6EC1_BCCD));
         end
      end
      chk("t1_latency", 64'(lat), 64'(15));
      step();
      chk("t1_in_flight", 64'(s_in_flight), 64'(0));

      // Two requesters contending
      sent0 = 0; sent1 = 0; ng = 0;
      for (int c = 0; c < 60 && (sent0 < 6 || sent1 < 6); c++) begin
         req_valid = {1'(sent1 < 6), 1'(sent0 < 6)};
         rand_data();
         step();
         if (s_req_ready[0]) sent0++;
         if (s_req_ready[1]) sent1++;
         if (s_req_ready != 0 && ng < 4) begin gseq[ng] = s_req_ready; ng++; end
      end
      req_valid = '0;
      chk("t2_sent0", 64'(sent0), 64'(6));
      chk("t2_sent1", 64'(sent1), 64'(6));
      chk("t2_g0", 64'(gseq[0]), 64'(2'b10));
      chk("t2_g1", 64'(gseq[1]), 64'(2'b01));
      chk("t2_g2", 64'(gseq[2]), 64'(2'b10));
      chk("t2_g3", 64'(gseq[3]), 64'(2'b01));
      repeat (20) step();

      // Back-to-back stream from one requester
      nacc = 0; peak = 0; nrsp = 0; first = -1; last = -1;
      for (int c = 0; c < 15; c++) begin
         req_valid = 2'b10; rand_data();
         step();
         if (s_req_ready[1]) nacc++;
         if (int'(s_in_flight) > peak) peak = int'(s_in_flight);
      end
      req_valid = '0;
      for (int c = 0; c < 25; c++) begin
         step();
         if (int'(s_in_flight) > peak) peak = int'(s_in_flight);
         if (s_rsp_valid[1]) begin
            nrsp++;
            if (first < 0) first = c;
            last = c;
         end
      end
      chk("t3_accepts", 64'(nacc), 64'(15));
      chk("t3_peak", 64'(peak), 64'(15));
      chk("t3_rsp_cnt", 64'(nrsp), 64'(15));
      chk("t3_rsp_run", 64'(last - first + 1), 64'(15));

      // Back-pressure on requester 0 with later results queued behind it
      rsp_ready = 2'b10;
      req_valid = 2'b01; rand_data(); step();
      req_valid = 2'b10; rand_data(); step();
      req_valid = 2'b01; rand_data(); step();
      req_valid = '0;
      lat = 0;
      for (int k = 0; k < 30 && lat == 0; k++) begin
         step();
         if (s_rsp_valid[0]) lat = 1;
      end
      chk("t4_reached", 64'(lat), 64'(1));
      held = s_rsp_data;
      nbad = 0;
      req_valid = 2'b11;
      repeat (5) begin
         step();
         if (s_clk_en || s_req_ready != 0 || s_rsp_data != held || s_rsp_valid != 2'b01) nbad++;
      end
      chk("t4_stalled", 64'(nbad), 64'(0));
      req_valid = '0; rsp_ready = 2'b11;
      repeat (25) step();
      chk("t4_drained", 64'(s_in_flight), 64'(0));

      // Reset with ops in flight
      for (int c = 0; c < 7; c++) begin
         req_valid = 2'b01; rand_data(); step();
      end
      req_valid = '0; reset = 1'b1;
      step();
      chk("t5_before", 64'(s_in_flight), 64'(7));
      reset = 1'b0;
      nbad = 0;
      repeat (20) begin
         step();
         if (s_rsp_valid != 0) nbad++;
      end
      chk("t5_no_rsp", 64'(nbad), 64'(0));
      chk("t5_in_flight", 64'(s_in_flight), 64'(0));
      req_valid = 2'b10; rand_data();
      step();
      chk("t5_accept", 64'(s_req_ready), 64'(2'b10));
      req_valid = '0;
      lat = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         step();
         if (s_rsp_valid[1]) lat = k;
      end
      chk("t5_latency", 64'(lat), 64'(15));

      // Random traffic, back-pressure and occasional reset
      for (int c = 0; c < 600; c++) begin
         req_valid = NUM_REQ'($urandom());
         for (int i = 0; i < int'(NUM_REQ); i++) rsp_ready[i] = ($urandom_range(0, 9) < 7);
         reset = ($urandom_range(0, 199) == 0);
         rand_data();
         step();
      end
      reset = 1'b0; req_valid = '0; rsp_ready = 2'b11;
      repeat (20) step();
      chk("final_in_flight", 64'(s_in_flight), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
